// File: rtl/sigmoid_result_line_writer.sv
// Packs the 4-lane post-sigmoid token stream into result-buffer lines and
// writes one tile's worth of lines per start command, pulsing done at the end.
module sigmoid_result_line_writer #(
   parameter int TILE_SIZE  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DATA_W     = 256,
   parameter int D          = 256,
   parameter int ADDR_W     = 6
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start_valid,
   output logic                             start_ready,
   input  logic [ADDR_W-1:0]                start_base,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0]  s_vec,
   output logic                             wr_en,
   input  logic                             wr_ready,
   output logic [ADDR_W-1:0]                wr_addr,
   output logic [DATA_W-1:0]                wr_data,
   output logic                             busy,
   output logic                             done
);

   localparam int TOK_W           = TILE_SIZE * DATA_WIDTH;
   localparam int LINE_TOKENS     = DATA_W / TOK_W;
   localparam int TOKENS_PER_TILE = D / TILE_SIZE;
   localparam int CNT_W           = $clog2(TOKENS_PER_TILE + 1);
   localparam int SLOT_W          = (LINE_TOKENS > 1) ? $clog2(LINE_TOKENS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LINE_TOKENS - 1);
   localparam logic [CNT_W-1:0]  LAST_TOK  = CNT_W'(TOKENS_PER_TILE - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t              state;
   state_t              state_next;
   logic [SLOT_W-1:0]   slot;
   logic [CNT_W-1:0]    tok_cnt;
   logic [DATA_W-1:0]   asm_line;
   logic [DATA_W-1:0]   line_next;
   logic [DATA_W-1:0]   pend_line;
   logic                pend_valid;
   logic [ADDR_W-1:0]   line_addr;
   logic                done_q;
   logic                s_fire;
   logic                w_fire;
   logic                c_fire;
   logic                line_done;
   logic                last_tok;

   // Valid/ready: a transfer happens on a cycle where both are high; the
   // producer holds its payload stable while valid is high and ready is low.
   // start_ready stays low during the done cycle so a held command starts
   // only on the cycle after done.
   assign start_ready = (state == IDLE) && !done_q;
   // The last slot may only fire if the pending line frees up this cycle.
   assign s_ready     = (state == COLLECT) &&
                        ((slot != LAST_SLOT) || !pend_valid || wr_ready);

   assign c_fire    = start_valid && start_ready;
   assign s_fire    = s_valid && s_ready;
   assign w_fire    = wr_en && wr_ready;
   assign line_done = s_fire && (slot == LAST_SLOT);
   assign last_tok  = (tok_cnt == LAST_TOK);

   assign wr_en   = pend_valid;
   assign wr_addr = line_addr;
   assign wr_data = pend_line;
   assign busy    = (state != IDLE);
   assign done    = done_q;

   // Assembly line with the current token merged into its slot.
   always_comb begin
      line_next = asm_line;
      line_next[slot*TOK_W +: TOK_W] = s_vec;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (c_fire) state_next = COLLECT;
         COLLECT: if (s_fire && last_tok) state_next = DRAIN;
         DRAIN:   if (w_fire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         slot       <= '0;
         tok_cnt    <= '0;
         asm_line   <= '0;
         pend_line  <= '0;
         pend_valid <= 1'b0;
         line_addr  <= '0;
         done_q     <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= (state == DRAIN) && w_fire;

         if (c_fire) begin
            line_addr <= start_base;
            tok_cnt   <= '0;
            slot      <= '0;
         end else begin
            if (w_fire) line_addr <= line_addr + 1'b1;
            if (s_fire) begin
               asm_line <= line_next;
               tok_cnt  <= tok_cnt + 1'b1;
               slot     <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            end
         end

         // A line completing in the same cycle as a write keeps pend_valid set.
         if (line_done) begin
            pend_line  <= line_next;
            pend_valid <= 1'b1;
         end else if (w_fire) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sigmoid_result_line_writer.sv
// Randomized bench for sigmoid_result_line_writer: each tile's expected lines
// are built from the token list and compared on every write handshake.
module tb_sigmoid_result_line_writer;

   localparam int TOK_W  = 64;
   localparam int DATA_W = 256;
   localparam int ADDR_W = 6;
   localparam int NTOK   = 64;
   localparam int NLINE  = 16;
   localparam int LT     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_valid;
   logic              start_ready;
   logic [ADDR_W-1:0] start_base;
   logic              s_valid;
   logic              s_ready;
   logic [TOK_W-1:0]  s_vec;
   logic              wr_en;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [TOK_W-1:0]  tok [NTOK];
   logic [DATA_W-1:0] mem [64];
   logic [DATA_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];

   always #5 clk = ~clk;

   sigmoid_result_line_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_base  (start_base),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_vec       (s_vec),
      .wr_en       (wr_en),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic make_tokens(input bit pattern);
      for (int t = 0; t < NTOK; t++)
         for (int i = 0; i < 4; i++)
            tok[t][i*16 +: 16] = pattern ? 16'(32'h0100 * t + i) : 16'($urandom);
   endtask

   // Line k of a tile holds tokens 4k..4k+3, token 4k in the low bits.
   function automatic logic [DATA_W-1:0] pack_line(input int k);
      logic [DATA_W-1:0] line;
      line = '0;
      for (int j = 0; j < LT; j++) line[j*TOK_W +: TOK_W] = tok[LT*k + j];
      return line;
   endfunction

   // wmode: percent chance of wr_ready, or 0 for wr_ready on 1 of every 3 cycles.
   task automatic run_tile(input logic [ADDR_W-1:0] base, input int vpct, input int wmode,
                           input bit keep_start, input logic [ADDR_W-1:0] next_base,
                           input int abort_after, output int n_done, output int n_acc);
      int acc;
      bit pend_m, exp_done, prev_stall, exp_sready, s_fire_m, w_fire_m, line_cmp, finished;
      logic [ADDR_W-1:0] prev_addr, ea;
      logic [DATA_W-1:0] prev_data, ed;
      acc = 0; pend_m = 0; exp_done = 0; prev_stall = 0; finished = 0;
      n_done = 0; n_acc = 0;
      prev_addr = '0; prev_data = '0;
      exp_q.delete(); exp_addr_q.delete();
      for (int a = 0; a < 64; a++) mem[a] = 'x;
      for (int k = 0; k < NLINE; k++) begin
         exp_q.push_back(pack_line(k));
         exp_addr_q.push_back(ADDR_W'(int'(base) + k));
      end

      // command phase: junk tokens offered while idle must not be taken
      start_valid = 1'b1; start_base = base;
      s_valid = 1'b1; s_vec = {$urandom, $urandom}; wr_ready = 1'(($urandom_range(0, 1)));
      #1;
      total_cnt++;
      if (start_ready !== 1'b1) $display("FAIL cmd_ready: got %b expected 1", start_ready);
      else pass_cnt++;
      total_cnt++;
      if (s_ready !== 1'b0) $display("FAIL idle_s_ready: got %b expected 0", s_ready);
      else pass_cnt++;
      total_cnt++;
      if (wr_en !== 1'b0) $display("FAIL idle_wr_en: got %b expected 0", wr_en);
      else pass_cnt++;
      if (start_ready !== 1'b1) begin
         for (int w = 0; w < 20 && start_ready !== 1'b1; w++) begin
            @(posedge clk); #1;
         end
         if (start_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL cmd_timeout: start_ready never rose, got %b expected 1", start_ready);
            start_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      start_valid = keep_start; start_base = next_base;

      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         s_valid  = (acc < NTOK) ? ($urandom_range(0, 99) < vpct) : 1'($urandom_range(0, 1));
         s_vec    = (acc < NTOK) ? tok[acc] : {$urandom, $urandom};
         wr_ready = (wmode == 0) ? (cyc % 3 == 0) : ($urandom_range(0, 99) < wmode);
         #1;
         exp_sready = (acc < NTOK) && ((acc % LT != LT - 1) || !pend_m || wr_ready);
         s_fire_m   = s_valid && exp_sready;
         line_cmp   = s_fire_m && (acc % LT == LT - 1);
         w_fire_m   = pend_m && wr_ready;

         total_cnt++;
         if (done !== exp_done) $display("FAIL done: got %b expected %b (acc %0d)", done, exp_done, acc);
         else pass_cnt++;
         total_cnt++;
         if (busy !== !exp_done) $display("FAIL busy: got %b expected %b", busy, !exp_done);
         else pass_cnt++;
         total_cnt++;
         if (start_ready !== 1'b0) $display("FAIL start_ready_busy: got %b expected 0", start_ready);
         else pass_cnt++;
         total_cnt++;
         if (s_ready !== exp_sready) $display("FAIL s_ready: got %b expected %b (acc %0d)", s_ready, exp_sready, acc);
         else pass_cnt++;
         total_cnt++;
         if (wr_en !== pend_m) $display("FAIL wr_en: got %b expected %b (acc %0d)", wr_en, pend_m, acc);
         else pass_cnt++;
         if (prev_stall) begin
            total_cnt++;
            if ({wr_addr, wr_data} !== {prev_addr, prev_data})
               $display("FAIL stall_hold: got addr %0d data %h expected addr %0d data %h",
                        wr_addr, wr_data, prev_addr, prev_data);
            else pass_cnt++;
         end
         if (w_fire_m) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_write: got write to addr %0d expected none", wr_addr);
            end else begin
               pass_cnt++;
               ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
               total_cnt++;
               if (wr_addr !== ea) $display("FAIL wr_addr: got %0d expected %0d", wr_addr, ea);
               else pass_cnt++;
               total_cnt++;
               if (wr_data !== ed) $display("FAIL wr_data: got %h expected %h", wr_data, ed);
               else pass_cnt++;
               mem[wr_addr] = wr_data;
            end
         end
         if (done === 1'b1) n_done++;
         if (exp_done || done === 1'b1) begin
            finished = 1;
         end else begin
            prev_stall = pend_m && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            exp_done   = w_fire_m && (acc == NTOK);
            pend_m     = line_cmp ? 1'b1 : (w_fire_m ? 1'b0 : pend_m);
            if (s_fire_m) acc++;
            @(posedge clk); #1;
            if (abort_after > 0 && acc >= abort_after) begin
               n_acc = acc;
               return;
            end
         end
      end
      if (!finished) begin
         total_cnt++;
         $display("FAIL tile_timeout: got no done after 3000 cycles expected done (acc %0d)", acc);
      end
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL lines_left: got %0d unwritten lines expected 0", exp_q.size());
      else pass_cnt++;
      n_acc = acc;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_valid = 1'b0; start_base = '0;
      s_valid = 1'b1; s_vec = {$urandom, $urandom}; wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({start_ready, s_ready, wr_en, busy, done, wr_addr} !== {5'b10000, 6'd0})
         $display("FAIL reset_ctrl: got %b expected %b",
                  {start_ready, s_ready, wr_en, busy, done, wr_addr}, {5'b10000, 6'd0});
      else pass_cnt++;
      total_cnt++;
      if (wr_data !== '0) $display("FAIL reset_data: got %h expected 0", wr_data);
      else pass_cnt++;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({s_ready, busy, wr_en} !== 3'b000)
         $display("FAIL idle_ignore: got %b expected 000", {s_ready, busy, wr_en});
      else pass_cnt++;
   endtask

   task automatic test_basic();
      int nd, na;
      make_tokens(1);
      run_tile(6'd0, 100, 100, 1'b0, 6'd0, 0, nd, na);
      total_cnt++;
      if (nd !== 1) $display("FAIL basic_done_count: got %0d expected 1", nd);
      else pass_cnt++;
      total_cnt++;
      if (na !== NTOK) $display("FAIL basic_tokens: got %0d expected %0d", na, NTOK);
      else pass_cnt++;
      total_cnt++;
      if (mem[0] !== {16'h0303, 16'h0302, 16'h0301, 16'h0300, 16'h0203, 16'h0202, 16'h0201, 16'h0200,
                      16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0003, 16'h0002, 16'h0001, 16'h0000})
         $display("FAIL basic_line0: got %h expected tokens 0..3", mem[0]);
      else pass_cnt++;
      total_cnt++;
      if (mem[15] !== pack_line(15)) $display("FAIL basic_line15: got %h expected %h", mem[15], pack_line(15));
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int nd, na;
      make_tokens(1);
      run_tile(6'd0, 100, 0, 1'b0, 6'd0, 0, nd, na);
      total_cnt++;
      if (nd !== 1) $display("FAIL bp_done_count: got %0d expected 1", nd);
      else pass_cnt++;
      total_cnt++;
      if (na !== NTOK) $display("FAIL bp_tokens: got %0d expected %0d", na, NTOK);
      else pass_cnt++;
   endtask

   task automatic test_sparse();
      int nd, na;
      make_tokens(1);
      run_tile(6'd0, 30, 100, 1'b0, 6'd0, 0, nd, na);
      total_cnt++;
      if (nd !== 1) $display("FAIL sparse_done_count: got %0d expected 1", nd);
      else pass_cnt++;
      for (int k = 0; k < NLINE; k++) begin
         total_cnt++;
         if (mem[k] !== pack_line(k)) $display("FAIL sparse_line: got %h expected %h at %0d", mem[k], pack_line(k), k);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap();
      int nd, na;
      make_tokens(0);
      run_tile(6'd56, 100, 70, 1'b0, 6'd0, 0, nd, na);
      total_cnt++;
      if (mem[0] !== pack_line(8)) $display("FAIL wrap_line_at_0: got %h expected %h", mem[0], pack_line(8));
      else pass_cnt++;
      total_cnt++;
      if (mem[63] !== pack_line(7)) $display("FAIL wrap_line_at_63: got %h expected %h", mem[63], pack_line(7));
      else pass_cnt++;
      total_cnt++;
      if (nd !== 1) $display("FAIL wrap_done_count: got %0d expected 1", nd);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int nd, na;
      make_tokens(0);
      run_tile(6'd0, 90, 80, 1'b1, 6'd16, 0, nd, na);
      total_cnt++;
      if (nd !== 1) $display("FAIL b2b_tile1_done: got %0d expected 1", nd);
      else pass_cnt++;
      make_tokens(0);
      run_tile(6'd16, 80, 90, 1'b0, 6'd0, 0, nd, na);
      total_cnt++;
      if (mem[16] !== pack_line(0)) $display("FAIL b2b_line16: got %h expected %h", mem[16], pack_line(0));
      else pass_cnt++;
      total_cnt++;
      if (mem[31] !== pack_line(15)) $display("FAIL b2b_line31: got %h expected %h", mem[31], pack_line(15));
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int nd, na;
      make_tokens(0);
      run_tile(6'd40, 70, 80, 1'b0, 6'd0, 20, nd, na);
      total_cnt++;
      if (na !== 20) $display("FAIL abort_tokens: got %0d expected 20", na);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({start_ready, s_ready, wr_en, busy, done, wr_addr} !== {5'b10000, 6'd0})
         $display("FAIL midreset_ctrl: got %b expected %b",
                  {start_ready, s_ready, wr_en, busy, done, wr_addr}, {5'b10000, 6'd0});
      else pass_cnt++;
      total_cnt++;
      if (wr_data !== '0) $display("FAIL midreset_data: got %h expected 0", wr_data);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if ({done, busy} !== 2'b00) $display("FAIL midreset_no_done: got %b expected 00", {done, busy});
      else pass_cnt++;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      make_tokens(1);
      run_tile(6'd5, 100, 60, 1'b0, 6'd0, 0, nd, na);
      total_cnt++;
      if (nd !== 1) $display("FAIL fresh_done_count: got %0d expected 1", nd);
      else pass_cnt++;
      total_cnt++;
      if (mem[5] !== pack_line(0)) $display("FAIL fresh_line_at_5: got %h expected %h", mem[5], pack_line(0));
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_sparse();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
